// File: rtl/ce_debounce_pkg.sv
// Shared types and width helpers for the clock-enable paced debouncer.
// Long-press support is enabled by defining CE_DEBOUNCE_LONG_PRESS_EN.
package ce_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISING,
    S_HIGH,
    S_FALLING
  } deb_state_t;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, ce-paced FSM, optional long counter.
// Long-press counter present only with CE_DEBOUNCE_LONG_PRESS_EN.
module debounce_chan
  import ce_debounce_pkg::*;
#(
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CNT    = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic din,
  output logic dout,
  output logic rise,
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
  output logic fall,
  output logic long_press
`else
  output logic fall
`endif
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT);

  logic [SYNC_STAGES-1:0] sync;
  logic s;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign s = sync[SYNC_STAGES-1];

  deb_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic hi, hi_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (ce) begin
      unique case (state)
        S_LOW: begin
          if (s) begin
            if (STABLE_CNT == 1) begin
              state_nx = S_HIGH;
            end else begin
              state_nx = S_RISING;
              cnt_nx   = CW'(1);
            end
          end
        end
        S_RISING: begin
          if (!s) begin
            state_nx = S_LOW;
            cnt_nx   = '0;
          end else if (cnt + CW'(1) == CMAX) begin
            state_nx = S_HIGH;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (!s) begin
            if (STABLE_CNT == 1) begin
              state_nx = S_LOW;
            end else begin
              state_nx = S_FALLING;
              cnt_nx   = CW'(1);
            end
          end
        end
        S_FALLING: begin
          if (s) begin
            state_nx = S_HIGH;
            cnt_nx   = '0;
          end else if (cnt + CW'(1) == CMAX) begin
            state_nx = S_LOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign hi    = (state == S_HIGH) || (state == S_FALLING);
  assign hi_nx = (state_nx == S_HIGH) || (state_nx == S_FALLING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dout  <= hi_nx;
      rise  <= hi_nx & ~hi;
      fall  <= ~hi_nx & hi;
    end
  end

`ifdef CE_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = cnt_width(LONG_CNT);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CNT);

  logic [LW-1:0] lcnt, lcnt_nx;
  logic lp_nx;

  // Counts ce samples spent high; saturates so the pulse fires once.
  always_comb begin
    lcnt_nx = lcnt;
    lp_nx   = 1'b0;
    if (ce) begin
      if (!hi_nx) begin
        lcnt_nx = '0;
      end else if (hi && lcnt != LMAX) begin
        lcnt_nx = lcnt + LW'(1);
        lp_nx   = (lcnt + LW'(1) == LMAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt       <= '0;
      long_press <= 1'b0;
    end else begin
      lcnt       <= lcnt_nx;
      long_press <= lp_nx;
    end
  end
`endif

endmodule

// File: rtl/ce_debounce.sv
// Multi-channel debouncer paced by an external clock-enable pulse.
// Define CE_DEBOUNCE_LONG_PRESS_EN to add the long_press output.
module ce_debounce
  import ce_debounce_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CNT    = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
`else
  output logic [CHANNELS-1:0] fall
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_CNT   (LONG_CNT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .din       (din[i]),
      .dout      (dout[i]),
      .rise      (rise[i]),
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
      .fall      (fall[i]),
      .long_press(long_press[i])
`else
      .fall      (fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_ce_debounce.sv
// Randomised bench for ce_debounce against a run-length reference model.
// Long-press checks are active when CE_DEBOUNCE_LONG_PRESS_EN is defined.
module tb_ce_debounce;

  localparam int CH     = 4;
  localparam int STABLE = 4;
  localparam int SYNC   = 2;
  localparam int LONG   = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic [CH-1:0] din = '0;
  logic [CH-1:0] dout, rise, fall;
  logic [CH-1:0] long_press;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ce_debounce #(
    .CHANNELS   (CH),
    .STABLE_CNT (STABLE),
    .SYNC_STAGES(SYNC),
    .LONG_CNT   (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .din       (din),
    .dout      (dout),
    .rise      (rise),
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
    .fall      (fall),
    .long_press(long_press)
`else
    .fall      (fall)
`endif
  );

`ifndef CE_DEBOUNCE_LONG_PRESS_EN
  assign long_press = '0;
`endif

  // Reference: din history for sync delay, per-channel run of
  // ce-samples disagreeing with the accepted level, long-hold count.
  logic [CH-1:0] hist [SYNC];
  logic [CH-1:0] m_dout = '0, m_rise = '0, m_fall = '0, m_lp = '0;
  int run [CH];
  int lc  [CH];
  int ce_mode = 0;
  int div = 0;
  int n_rise = 0, n_fall = 0, n_lp = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    logic s, cur, nxt;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
      for (int c = 0; c < CH; c++) begin
        run[c] = 0;
        lc[c]  = 0;
      end
      m_dout = '0; m_rise = '0; m_fall = '0; m_lp = '0;
      return;
    end
    m_rise = '0; m_fall = '0; m_lp = '0;
    for (int c = 0; c < CH; c++) begin
      s   = hist[SYNC-1][c];
      cur = m_dout[c];
      nxt = cur;
      if (ce) begin
        if (s != cur) begin
          run[c]++;
          if (run[c] == STABLE) begin
            nxt    = ~cur;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
        if (!nxt) lc[c] = 0;
        else if (cur && lc[c] < LONG) begin
          lc[c]++;
          if (lc[c] == LONG) m_lp[c] = 1'b1;
        end
      end
      m_rise[c] = nxt & ~cur;
      m_fall[c] = ~nxt & cur;
      m_dout[c] = nxt;
    end
    for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = din;
  endtask

  task automatic step(input logic [CH-1:0] d);
    @(negedge clk);
    din = d;
    case (ce_mode)
      1:       ce = 1'b1;
      2:       ce = ($urandom_range(0, 3) == 0);
      default: begin
        ce  = (div == 9);
        div = (div == 9) ? 0 : div + 1;
      end
    endcase
    @(posedge clk);
    model_edge();
    #1;
    check("dout", 32'(dout), 32'(m_dout));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("rise_fall_excl", 32'(rise & fall), 32'h0);
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
    check("long_press", 32'(long_press), 32'(m_lp));
`endif
    n_rise += $countones(rise);
    n_fall += $countones(fall);
    n_lp   += $countones(long_press);
  endtask

  task automatic hold(input logic [CH-1:0] d, input int n);
    for (int i = 0; i < n; i++) step(d);
  endtask

  initial begin
    logic [CH-1:0] d;
    int base_r, base_f, base_lp;

    for (int k = 0; k < SYNC; k++) hist[k] = '0;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      lc[c]  = 0;
    end

    // Reset for three clocks with quiet inputs.
    rst = 1'b1;
    hold('0, 3);
    rst = 1'b0;
    hold('0, 30);
    check("quiet_rise_cnt", 32'(n_rise + n_fall), 32'h0);

    // Clean rising edge on channel 0.
    base_r = n_rise;
    hold(4'h1, 80);
    check("ch0_level", 32'(dout[0]), 32'h1);
    check("ch0_one_rise", 32'(n_rise - base_r), 32'h1);
    hold(4'h0, 60);

    // Channel 1 bouncing every 15 clk never settles.
    base_r = n_rise;
    d = 4'h0;
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 0) d[1] = ~d[1];
      step(d);
    end
    check("bounce_no_pulse", 32'(n_rise - base_r), 32'h0);
    hold(4'h0, 60);

    // All channels together, up then down.
    base_r = n_rise;
    base_f = n_fall;
    hold(4'hF, 70);
    hold(4'h0, 70);
    check("all_rise", 32'(n_rise - base_r), 32'h4);
    check("all_fall", 32'(n_fall - base_f), 32'h4);

    // Random bouncing with random ce spacing.
    ce_mode = 2;
    d = '0;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) d[c] = ~d[c];
      step(d);
    end
    ce_mode = 0;
    hold(4'h0, 80);

    // ce tied high: short glitch rejected, 6-clk hold accepted.
    ce_mode = 1;
    base_r = n_rise;
    hold(4'h4, 3);
    hold(4'h0, 10);
    check("ce1_glitch", 32'(n_rise - base_r), 32'h0);
    hold(4'h4, 6);
    hold(4'h4, 1);
    check("ce1_rise", 32'(n_rise - base_r), 32'h1);
    hold(4'h0, 10);
    ce_mode = 0;
    div = 0;

    // Long hold on channel 3, reset part way through.
    base_lp = n_lp;
    base_f  = n_fall;
    hold(4'h8, 300);
`ifdef CE_DEBOUNCE_LONG_PRESS_EN
    check("long_once", 32'(n_lp - base_lp), 32'h1);
`endif
    rst = 1'b1;
    step(4'h8);
    check("rst_dout", 32'(dout[3]), 32'h0);
    rst = 1'b0;
    hold(4'h0, 40);
    check("rst_no_fall", 32'(n_fall - base_f), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
